// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared id_kind encodings and default addresses
// for the fetch PC generator.
package pc_gen_pkg;

   typedef enum logic [2:0] {
      KIND_NONE = 3'd0,
      KIND_J    = 3'd1,
      KIND_JAL  = 3'd2,
      KIND_BR   = 3'd3,
      KIND_JR   = 3'd4,
      KIND_JALR = 3'd5
   } kind_e;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

   function automatic logic [31:0] br_target(
      input logic [31:0] pc,
      input logic [31:0] instr
   );
      logic [31:0] off;
      off = {{14{instr[15]}}, instr[15:0], 2'b00};
      return pc + 32'd4 + off;
   endfunction

endpackage

// File: rtl/pc_gen_ras_if.sv
// pc_gen_ras_if: ID-stage control-transfer bundle presented
// by the decoder to the PC generator.
interface pc_gen_ras_if;

   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [2:0]  id_kind;
   logic [31:0] id_rs_val;

   modport master (
      output id_valid, id_pc, id_instr,
      output id_kind, id_rs_val
   );

   modport slave (
      input id_valid, id_pc, id_instr,
      input id_kind, id_rs_val
   );

endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; full push drops
// the oldest entry, push+pop together replaces the top.
module ras_stack #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_data,
   output logic [31:0] top,
   output logic        empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_m1;
   logic [CW-1:0] cnt;

   assign ptr_m1 = ptr - AW'(1);
   assign top    = mem[ptr_m1];
   assign empty  = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         ptr <= '0;
         cnt <= '0;
      end else if (push && pop && !empty) begin
         mem[ptr_m1] <= push_data;
      end else if (push) begin
         mem[ptr] <= push_data;
         ptr      <= ptr + AW'(1);
         if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr_m1;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch PC register, next-PC priority mux and
// RAS prediction with one-cycle-late repair.
module pc_gen_ras
   import pc_gen_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
   parameter int          RAS_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   pc_gen_ras_if.slave id,
   input  logic [31:0] ex_rs_val,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        ras_pred,
   output logic        flush
);

   logic        chk_valid;
   logic [31:0] chk_pred;
   logic        mismatch;
   logic        id_sel;
   logic        rs31;
   logic        is_jr;
   logic        is_jal;
   logic        is_jalr;
   logic        push;
   logic        pop;
   logic        ras_empty;
   logic [31:0] ras_top;
   logic [31:0] link;
   logic [31:0] jtgt;
   logic [31:0] nxt;

   assign rs31    = (id.id_instr[25:21] == 5'd31);
   assign is_jr   = (id.id_kind == KIND_JR);
   assign is_jal  = (id.id_kind == KIND_JAL);
   assign is_jalr = (id.id_kind == KIND_JALR);
   assign link    = id.id_pc + 32'd8;
   assign jtgt    = {id.id_pc[31:28], id.id_instr[25:0], 2'b00};

   // a stalled check is frozen, not evaluated
   assign mismatch = chk_valid && !stall
                     && (ex_rs_val != chk_pred);

   assign id_sel = reset_n && !exc_req && !eret_req
                   && !mismatch && !stall && id.id_valid;

   assign ras_pred = id_sel && is_jr && rs31 && !ras_empty;
   assign push     = id_sel && (is_jal || is_jalr);
   assign pop      = id_sel && rs31 && (is_jr || is_jalr)
                     && !ras_empty;
   assign flush    = reset_n && mismatch
                     && !exc_req && !eret_req;

   always_comb begin
      nxt = pc + 32'd4;
      if (id.id_valid) begin
         unique case (id.id_kind)
            KIND_J, KIND_JAL: nxt = jtgt;
            KIND_BR:   nxt = br_target(id.id_pc, id.id_instr);
            KIND_JR:   nxt = ras_pred ? ras_top : id.id_rs_val;
            KIND_JALR: nxt = id.id_rs_val;
            default:   nxt = pc + 32'd4;
         endcase
      end
   end

   always_comb begin
      npc = nxt;
      if (!reset_n)     npc = RESET_PC;
      else if (exc_req) npc = EXC_VECTOR;
      else if (eret_req) npc = epc;
      else if (mismatch) npc = ex_rs_val;
      else if (stall)   npc = pc;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc        <= RESET_PC;
         chk_valid <= 1'b0;
         chk_pred  <= '0;
      end else begin
         pc <= npc;
         if (ras_pred) begin
            chk_valid <= 1'b1;
            chk_pred  <= ras_top;
         end else if (exc_req || eret_req
                      || (chk_valid && !stall)) begin
            chk_valid <= 1'b0;
         end
      end
   end

   ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (link),
      .top       (ras_top),
      .empty     (ras_empty)
   );

endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: directed scenario bench for pc_gen_ras.
module tb_pc_gen_ras;

   localparam logic [31:0] JR31   = 32'h03E0_0008;
   localparam logic [31:0] JALR31 = 32'h03E0_F809;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic [31:0] ex_rs_val;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        ras_pred;
   logic        flush;

   int errors = 0;
   int checks = 0;

   pc_gen_ras_if idif ();

   pc_gen_ras #(
      .RESET_PC   (32'h0000_3000),
      .EXC_VECTOR (32'h0000_4180),
      .RAS_DEPTH  (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall     (stall),
      .id        (idif.slave),
      .ex_rs_val (ex_rs_val),
      .exc_req   (exc_req),
      .eret_req  (eret_req),
      .epc       (epc),
      .pc        (pc),
      .npc       (npc),
      .ras_pred  (ras_pred),
      .flush     (flush)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(
      input logic        v,
      input logic [31:0] ipc,
      input logic [31:0] ins,
      input logic [2:0]  k,
      input logic [31:0] rs
   );
      idif.id_valid  = v;
      idif.id_pc     = ipc;
      idif.id_instr  = ins;
      idif.id_kind   = k;
      idif.id_rs_val = rs;
   endtask

   task automatic idle();
      drive_id(1'b0, 32'h0, 32'h0, 3'd0, 32'h0);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      stall     = 1'b0;
      exc_req   = 1'b0;
      eret_req  = 1'b0;
      epc       = 32'h0;
      ex_rs_val = 32'h0;
      idle();
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      stall     = 1'b0;
      exc_req   = 1'b0;
      eret_req  = 1'b0;
      epc       = 32'h0;
      ex_rs_val = 32'h0;
      idle();
      step();
      step();
      checks++;
      if (pc !== 32'h3000) begin
         errors++;
         $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000);
      end
      checks++;
      if (flush !== 1'b0 || ras_pred !== 1'b0) begin
         errors++;
         $display("FAIL reset_out flush=%b pred=%b exp=0",
                  flush, ras_pred);
      end
      checks++;
      if (npc !== 32'h3000) begin
         errors++;
         $display("FAIL reset_npc got=%h exp=%h", npc, 32'h3000);
      end
      reset_n = 1'b1;
      step();
      checks++;
      if (pc !== 32'h3004) begin
         errors++;
         $display("FAIL seq1 got=%h exp=%h", pc, 32'h3004);
      end
      step();
      checks++;
      if (pc !== 32'h3008) begin
         errors++;
         $display("FAIL seq2 got=%h exp=%h", pc, 32'h3008);
      end
   endtask

   task automatic test_branch_jump();
      drive_id(1'b1, 32'h3010, 32'h1000_FFFF, 3'd3, 32'h0);
      #1;
      checks++;
      if (npc !== 32'h3010) begin
         errors++;
         $display("FAIL br_npc got=%h exp=%h", npc, 32'h3010);
      end
      step();
      checks++;
      if (pc !== 32'h3010) begin
         errors++;
         $display("FAIL br_pc got=%h exp=%h", pc, 32'h3010);
      end
      drive_id(1'b1, 32'h3010, 32'h0800_0C40, 3'd1, 32'h0);
      step();
      checks++;
      if (pc !== 32'h3100) begin
         errors++;
         $display("FAIL j_pc got=%h exp=%h", pc, 32'h3100);
      end
      drive_id(1'b1, 32'h3100, 32'h1000_0003, 3'd3, 32'h0);
      step();
      checks++;
      if (pc !== 32'h3110) begin
         errors++;
         $display("FAIL br_fwd got=%h exp=%h", pc, 32'h3110);
      end
      idle();
   endtask

   task automatic test_ras_match();
      do_reset();
      drive_id(1'b1, 32'h3000, 32'h0C00_0C40, 3'd2, 32'h0);
      step();
      checks++;
      if (pc !== 32'h3100) begin
         errors++;
         $display("FAIL jal_pc got=%h exp=%h", pc, 32'h3100);
      end
      drive_id(1'b1, 32'h3100, JR31, 3'd4, 32'hDEAD_0000);
      #1;
      checks++;
      if (ras_pred !== 1'b1 || npc !== 32'h3008) begin
         errors++;
         $display("FAIL jr_pred pred=%b npc=%h exp=1 %h",
                  ras_pred, npc, 32'h3008);
      end
      step();
      checks++;
      if (pc !== 32'h3008) begin
         errors++;
         $display("FAIL jr_pc got=%h exp=%h", pc, 32'h3008);
      end
      idle();
      ex_rs_val = 32'h3008;
      #1;
      checks++;
      if (flush !== 1'b0 || npc !== 32'h300C) begin
         errors++;
         $display("FAIL match flush=%b npc=%h exp=0 %h",
                  flush, npc, 32'h300C);
      end
      step();
   endtask

   task automatic test_mispredict();
      do_reset();
      drive_id(1'b1, 32'h3000, 32'h0C00_0C40, 3'd2, 32'h0);
      step();
      drive_id(1'b1, 32'h3100, JR31, 3'd4, 32'h0);
      step();
      idle();
      ex_rs_val = 32'h3200;
      #1;
      checks++;
      if (flush !== 1'b1 || npc !== 32'h3200) begin
         errors++;
         $display("FAIL mis flush=%b npc=%h exp=1 %h",
                  flush, npc, 32'h3200);
      end
      step();
      checks++;
      if (pc !== 32'h3200 || flush !== 1'b0) begin
         errors++;
         $display("FAIL mis_pc pc=%h flush=%b exp=%h 0",
                  pc, flush, 32'h3200);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] prev;
      logic [31:0] exp_t;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_id(1'b1, 32'h3000 + 32'(i) * 32'h10,
                  32'h0C00_0C40, 3'd2, 32'h0);
         step();
      end
      prev = 32'h0;
      for (int i = 0; i < 4; i++) begin
         exp_t = 32'h3008 + 32'(4 - i) * 32'h10;
         ex_rs_val = prev;
         drive_id(1'b1, 32'h3100, JR31, 3'd4, 32'h5555_0000);
         #1;
         checks++;
         if (ras_pred !== 1'b1 || npc !== exp_t) begin
            errors++;
            $display("FAIL lifo%0d pred=%b npc=%h exp=1 %h",
                     i, ras_pred, npc, exp_t);
         end
         prev = exp_t;
         step();
      end
      ex_rs_val = prev;
      drive_id(1'b1, 32'h3100, JR31, 3'd4, 32'h5555_0000);
      #1;
      checks++;
      if (ras_pred !== 1'b0 || npc !== 32'h5555_0000) begin
         errors++;
         $display("FAIL under pred=%b npc=%h exp=0 %h",
                  ras_pred, npc, 32'h5555_0000);
      end
      step();
      idle();
      ex_rs_val = 32'h1234;
      #1;
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL under_flush got=%b exp=0", flush);
      end
      step();
   endtask

   task automatic test_empty_jr();
      do_reset();
      drive_id(1'b1, 32'h3000, JR31, 3'd4, 32'h3300);
      #1;
      checks++;
      if (ras_pred !== 1'b0 || npc !== 32'h3300) begin
         errors++;
         $display("FAIL empty pred=%b npc=%h exp=0 %h",
                  ras_pred, npc, 32'h3300);
      end
      step();
      idle();
      ex_rs_val = 32'h9999;
      #1;
      checks++;
      if (flush !== 1'b0 || pc !== 32'h3300) begin
         errors++;
         $display("FAIL empty_nf flush=%b pc=%h exp=0 %h",
                  flush, pc, 32'h3300);
      end
      step();
   endtask

   task automatic test_jalr_replace();
      do_reset();
      drive_id(1'b1, 32'h3000, 32'h0C00_0C40, 3'd2, 32'h0);
      step();
      drive_id(1'b1, 32'h3100, JALR31, 3'd5, 32'h3400);
      #1;
      checks++;
      if (ras_pred !== 1'b0 || npc !== 32'h3400) begin
         errors++;
         $display("FAIL jalr pred=%b npc=%h exp=0 %h",
                  ras_pred, npc, 32'h3400);
      end
      step();
      drive_id(1'b1, 32'h3400, JR31, 3'd4, 32'h0);
      #1;
      checks++;
      if (ras_pred !== 1'b1 || npc !== 32'h3108) begin
         errors++;
         $display("FAIL jalr_top pred=%b npc=%h exp=1 %h",
                  ras_pred, npc, 32'h3108);
      end
      step();
      drive_id(1'b1, 32'h3500, JR31, 3'd4, 32'h6600);
      ex_rs_val = 32'h3108;
      #1;
      checks++;
      if (ras_pred !== 1'b0 || npc !== 32'h6600) begin
         errors++;
         $display("FAIL jalr_pop pred=%b npc=%h exp=0 %h",
                  ras_pred, npc, 32'h6600);
      end
      step();
      idle();
   endtask

   task automatic test_stall();
      do_reset();
      drive_id(1'b1, 32'h3000, 32'h0C00_0C40, 3'd2, 32'h0);
      step();
      stall = 1'b1;
      drive_id(1'b1, 32'h3100, JR31, 3'd4, 32'h7700);
      #1;
      checks++;
      if (ras_pred !== 1'b0 || npc !== 32'h3100) begin
         errors++;
         $display("FAIL stall pred=%b npc=%h exp=0 %h",
                  ras_pred, npc, 32'h3100);
      end
      step();
      checks++;
      if (pc !== 32'h3100) begin
         errors++;
         $display("FAIL stall_pc got=%h exp=%h", pc, 32'h3100);
      end
      stall = 1'b0;
      #1;
      checks++;
      if (ras_pred !== 1'b1 || npc !== 32'h3008) begin
         errors++;
         $display("FAIL stall_ras pred=%b npc=%h exp=1 %h",
                  ras_pred, npc, 32'h3008);
      end
      step();
      idle();
      stall = 1'b1;
      ex_rs_val = 32'h0BAD;
      #1;
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL stall_chk got=%b exp=0", flush);
      end
      step();
      stall = 1'b0;
      #1;
      checks++;
      if (flush !== 1'b1 || npc !== 32'h0BAD) begin
         errors++;
         $display("FAIL held_chk flush=%b npc=%h exp=1 %h",
                  flush, npc, 32'h0BAD);
      end
      step();
   endtask

   task automatic test_exc_priority();
      do_reset();
      drive_id(1'b1, 32'h3000, 32'h0C00_0C40, 3'd2, 32'h0);
      step();
      drive_id(1'b1, 32'h3100, JR31, 3'd4, 32'h0);
      step();
      idle();
      ex_rs_val = 32'h3200;
      exc_req = 1'b1;
      #1;
      checks++;
      if (flush !== 1'b0 || npc !== 32'h4180) begin
         errors++;
         $display("FAIL exc flush=%b npc=%h exp=0 %h",
                  flush, npc, 32'h4180);
      end
      step();
      exc_req = 1'b0;
      #1;
      checks++;
      if (pc !== 32'h4180 || flush !== 1'b0) begin
         errors++;
         $display("FAIL exc_pc pc=%h flush=%b exp=%h 0",
                  pc, flush, 32'h4180);
      end
      epc = 32'h3ABC;
      eret_req = 1'b1;
      exc_req = 1'b1;
      #1;
      checks++;
      if (npc !== 32'h4180) begin
         errors++;
         $display("FAIL exc_eret got=%h exp=%h", npc, 32'h4180);
      end
      exc_req = 1'b0;
      #1;
      checks++;
      if (npc !== 32'h3ABC) begin
         errors++;
         $display("FAIL eret got=%h exp=%h", npc, 32'h3ABC);
      end
      step();
      eret_req = 1'b0;
      checks++;
      if (pc !== 32'h3ABC) begin
         errors++;
         $display("FAIL eret_pc got=%h exp=%h", pc, 32'h3ABC);
      end
   endtask

   initial begin
      test_reset();
      test_branch_jump();
      test_ras_match();
      test_mispredict();
      test_overflow();
      test_empty_jr();
      test_jalr_replace();
      test_stall();
      test_exc_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
